adder_scheduler: RTL and testbench

ADDER_SCHEDULER -- requirements
Module: adder_scheduler

---
 rtl/adder_scheduler_if.sv | 28 ++
 rtl/adder_scheduler.sv | 169 ++++++++++++++++
 tb/tb_adder_scheduler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_scheduler_if.sv
// Request/response bus of the shared-adder scheduler.
// The master side drives requests and consumes responses; the slave side is the scheduler.
interface adder_scheduler_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [16*N_REQ-1:0]   req_a;
    logic [16*N_REQ-1:0]   req_b;
    logic [N_REQ-1:0]      req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_result;
    logic                  rsp_overflow;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
    );
endinterface

// File: rtl/adder_scheduler.sv
// Round-robin scheduler that time-shares one 16-bit carry-select adder
// between N_REQ requesters. Subtraction first negates B through the same
// adder (~B + 1), then adds; one operation is in flight at a time.

// 16-bit carry-select adder: low byte ripples, high byte is computed for both
// carry-in values and selected by the low-byte carry.
module csel_add16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] s
);
    logic [8:0] lo;
    logic [7:0] hi0;
    logic [7:0] hi1;

    assign lo  = {1'b0, x[7:0]} + {1'b0, y[7:0]};
    assign hi0 = x[15:8] + y[15:8];
    assign hi1 = x[15:8] + y[15:8] + 8'd1;
    assign s   = {(lo[8] ? hi1 : hi0), lo[7:0]};
endmodule

module adder_scheduler #(
    parameter int N_REQ = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_scheduler_if.slave    bus,
    output logic                busy
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, NEG, ADD, RESP} state_t;

    // Captured operation; b_sign keeps the original B sign because NEG overwrites b.
    typedef struct packed {
        logic [15:0]     a;
        logic [15:0]     b;
        logic            sub;
        logic            b_sign;
        logic [ID_W-1:0] id;
    } op_t;

    state_t                  state_q, state_d;
    op_t                     op_q;
    logic [ID_W-1:0]         last_id;
    logic [ID_W-1:0]         grant_id;
    logic                    grant_hit;
    logic [ID_W:0]           idx;
    logic [N_REQ-1:0]        ready;
    logic                    accept;
    logic [N_REQ-1:0][15:0]  a_lane;
    logic [N_REQ-1:0][15:0]  b_lane;
    logic [15:0]             add_x;
    logic [15:0]             add_y;
    logic [15:0]             sum;
    logic                    ovf;
    logic [ID_W-1:0]         rsp_id_q;
    logic [15:0]             rsp_result_q;
    logic                    rsp_overflow_q;

    assign a_lane = bus.req_a;
    assign b_lane = bus.req_b;

    // Round-robin search starting one past the last winner, wrapping at N_REQ.
    always_comb begin
        grant_id  = '0;
        grant_hit = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = {1'b0, last_id} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N_REQ))
                idx = idx - (ID_W+1)'(N_REQ);
            if (!grant_hit && bus.req_valid[idx[ID_W-1:0]]) begin
                grant_hit = 1'b1;
                grant_id  = idx[ID_W-1:0];
            end
        end
    end

    // Grant only in IDLE; reset masks it so ready is 0 while rst_n is low.
    always_comb begin
        ready = '0;
        if (rst_n && state_q == IDLE && grant_hit)
            ready[grant_id] = 1'b1;
    end

    assign bus.req_ready = ready;
    assign accept        = |(bus.req_valid & ready);

    // Single adder: NEG computes ~B + 1, ADD computes A + B.
    always_comb begin
        add_x = op_q.a;
        add_y = op_q.b;
        if (state_q == NEG) begin
            add_x = ~op_q.b;
            add_y = 16'd1;
        end
    end

    csel_add16 u_add (
        .x (add_x),
        .y (add_y),
        .s (sum)
    );

    // Overflow from the original operand signs and the final sum.
    always_comb begin
        ovf = 1'b0;
        if (op_q.sub)
            ovf = (op_q.a[15] != op_q.b_sign) && (sum[15] != op_q.a[15]);
        else
            ovf = (op_q.a[15] == op_q.b_sign) && (sum[15] != op_q.a[15]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = bus.req_sub[grant_id] ? NEG : ADD;
            NEG:  state_d = ADD;
            ADD:  state_d = RESP;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, B negation write-back, result registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q           <= '0;
            last_id        <= ID_W'(N_REQ-1);
            rsp_id_q       <= '0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q.a      <= a_lane[grant_id];
                    op_q.b      <= b_lane[grant_id];
                    op_q.sub    <= bus.req_sub[grant_id];
                    op_q.b_sign <= b_lane[grant_id][15];
                    op_q.id     <= grant_id;
                    last_id     <= grant_id;
                end
                NEG: op_q.b <= sum;
                ADD: begin
                    rsp_result_q   <= sum;
                    rsp_overflow_q <= ovf;
                    rsp_id_q       <= op_q.id;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid    = (state_q == RESP);
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign busy             = (state_q != IDLE);
endmodule

// File: tb/tb_adder_scheduler.sv
// Bench for adder_scheduler: directed vector table, multi-cycle corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_adder_scheduler;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    logic busy;

    adder_scheduler_if #(.N_REQ(N)) bus ();

    adder_scheduler #(.N_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rr_last = N - 1;

    logic [N-1:0] valid_drv;
    logic [15:0]  a_drv [N];
    logic [15:0]  b_drv [N];
    logic [N-1:0] sub_drv;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] r;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply();
        bus.req_valid = valid_drv;
        bus.req_sub   = sub_drv;
        for (int i = 0; i < N; i++) begin
            bus.req_a[16*i +: 16] = a_drv[i];
            bus.req_b[16*i +: 16] = b_drv[i];
        end
    endtask

    // Reference: exact integer arithmetic, wrapped to 16 bits.
    function automatic void ref_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                                   output logic [15:0] r, output logic o);
        int sa, sb, full;
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        full = s ? (sa - sb) : (sa + sb);
        r    = full[15:0];
        o    = (full > 32767) || (full < -32768);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    // One transaction from IDLE (called at posedge+1): grant, capture, scramble
    // the bus, wait for the response, optionally stall it, then consume it.
    task automatic run_one(input logic drop, input int hold,
                           output int gid, output logic [15:0] r, output logic o);
        int waitc, lat, exp_lat;
        logic [N-1:0] exp_rdy;
        logic [15:0] ca, cb, er;
        logic cs, eo;
        gid = -1; r = '0; o = 1'b0;
        bus.rsp_ready = (hold == 0);
        waitc = 0;
        #1;
        while (bus.req_ready == '0 && waitc < 20) begin
            @(posedge clk); #2;
            waitc++;
        end
        if (bus.req_ready == '0) begin
            chk("accept_timeout", 32'(bus.req_ready), 32'(valid_drv));
            return;
        end
        gid = rr_pick(valid_drv, rr_last);
        exp_rdy = '0;
        exp_rdy[gid] = 1'b1;
        chk("grant", 32'(bus.req_ready), 32'(exp_rdy));
        ca = a_drv[gid]; cb = b_drv[gid]; cs = sub_drv[gid];
        ref_op(ca, cb, cs, er, eo);
        exp_lat = cs ? 3 : 2;
        rr_last = gid;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            a_drv[i] = 16'($urandom);
            b_drv[i] = 16'($urandom);
        end
        sub_drv = N'($urandom);
        if (drop) valid_drv[gid] = 1'b0;
        apply();
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            chk("inflight_busy_ready", {busy, 31'(bus.req_ready)}, {1'b1, 31'd0});
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_id", 32'(bus.rsp_id), 32'(gid));
        chk("rsp_result", 32'(bus.rsp_result), 32'(er));
        chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(eo));
        r = bus.rsp_result;
        o = bus.rsp_overflow;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_stable",
                {bus.rsp_valid, bus.rsp_overflow, 2'(bus.rsp_id), bus.rsp_result, 4'(bus.req_ready)},
                {1'b1, eo, 2'(gid), er, 4'd0});
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("single_rsp", {30'd0, bus.rsp_valid, busy}, 32'd0);
    endtask

    initial begin
        int gid;
        logic [15:0] r;
        logic o;
        int order [5] = '{0, 1, 2, 3, 0};

        vecs[0] = '{2, 16'd100,  16'hFFE2, 1'b0, 16'd70,   1'b0};
        vecs[1] = '{0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1};
        vecs[2] = '{1, 16'h0005, 16'h8000, 1'b1, 16'h8005, 1'b1};
        vecs[3] = '{3, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1};
        vecs[4] = '{0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[5] = '{1, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0};
        vecs[6] = '{2, 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1};
        vecs[7] = '{3, 16'd10,   16'd3,    1'b1, 16'd7,    1'b0};
        vecs[8] = '{0, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b0};
        vecs[9] = '{2, 16'h1234, 16'h0FFF, 1'b1, 16'h0235, 1'b0};

        // Reset with every requester asking: nothing may be granted.
        rst_n = 1'b0;
        valid_drv = '1; sub_drv = '0;
        for (int i = 0; i < N; i++) begin a_drv[i] = 16'h1111; b_drv[i] = 16'h2222; end
        apply();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("reset_outputs",
            {busy, 4'(bus.req_ready), bus.rsp_valid, 2'(bus.rsp_id), bus.rsp_result, bus.rsp_overflow},
            '0);
        valid_drv = '0; apply();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rr_last = N - 1;

        // Directed vector table, single requester each.
        foreach (vecs[k]) begin
            valid_drv = '0;
            valid_drv[vecs[k].id] = 1'b1;
            a_drv[vecs[k].id] = vecs[k].a;
            b_drv[vecs[k].id] = vecs[k].b;
            sub_drv[vecs[k].id] = vecs[k].sub;
            apply();
            run_one(1'b1, 0, gid, r, o);
            chk("vec_gid", 32'(gid), 32'(vecs[k].id));
            chk("vec_result", 32'(r), 32'(vecs[k].r));
            chk("vec_ovf", 32'(o), 32'(vecs[k].ovf));
        end

        // Response stalled for 5 cycles.
        valid_drv = 4'b1000; a_drv[3] = 16'd1234; b_drv[3] = 16'd4321; sub_drv[3] = 1'b0;
        apply();
        run_one(1'b1, 5, gid, r, o);
        chk("stall_result", 32'(r), 32'd5555);

        // Fresh reset, all requesters held valid: grant order 0,1,2,3,0.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rr_last = N - 1;
        valid_drv = '1;
        for (int i = 0; i < N; i++) begin a_drv[i] = 16'($urandom); b_drv[i] = 16'($urandom); end
        sub_drv = N'($urandom);
        apply();
        for (int k = 0; k < 5; k++) begin
            run_one(1'b0, 0, gid, r, o);
            chk("rr_order", 32'(gid), 32'(order[k]));
        end
        valid_drv = '0; apply();

        // Reset pulsed during NEG drops the operation.
        valid_drv = 4'b0010; a_drv[1] = 16'd50; b_drv[1] = 16'd20; sub_drv[1] = 1'b1;
        apply();
        #1;
        chk("neg_grant", 32'(bus.req_ready), 32'h2);
        @(posedge clk); #1;
        chk("neg_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        valid_drv = 4'b0110; apply();
        #1;
        chk("midreset_outputs",
            {busy, 4'(bus.req_ready), bus.rsp_valid, 2'(bus.rsp_id), bus.rsp_result, bus.rsp_overflow},
            '0);
        @(posedge clk); #1;
        chk("midreset_no_rsp", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        rr_last = N - 1;
        run_one(1'b1, 0, gid, r, o);
        chk("post_reset_gid", 32'(gid), 32'd1);
        run_one(1'b1, 0, gid, r, o);
        chk("post_reset_gid2", 32'(gid), 32'd2);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 40; k++) begin
            valid_drv = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin a_drv[i] = rnd16(); b_drv[i] = rnd16(); end
            sub_drv = N'($urandom);
            apply();
            run_one(1'($urandom), $urandom_range(0, 2), gid, r, o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
